mcpu: RTL

Multi-cycle MIPS-subset CPU core, the parametrised successor to the single-cycle core. Keeps the same memory/IO-facing port set, but executes each instruction over an FSM of 3–5 states. Stalls on `MIO_ready` for every data access. Adds a vectored interrupt with EPC save and `eret` return. Drops into the same SoC slot: `PC_out` feeds instruction ROM, and `Addr_out`/`Data_out`/`mem_w`/`CPU_MIO` feed the memory/IO bus.

---
 rtl/mcpu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mcpu.sv
// mcpu: multi-cycle MIPS-subset core with a MIO_ready-stalled data bus and a
// single-level vectored interrupt (EPC save, eret return).
module mcpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0004,
    parameter logic        IRQ_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [31:0] Data_in,
    input  logic        INT,
    input  logic        MIO_ready,
    output logic [31:0] PC_out,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic        mem_w,
    output logic        CPU_MIO,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_INTR   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q, epc_q;
    logic        ie_q;
    logic [31:0] rf_q [0:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_dst;
    logic [31:0] imm_s, imm_z, br_off, jmp_tgt;
    logic        is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr, is_eret;
    logic        br_taken, int_take;
    logic        alu_vld;
    logic [31:0] alu_res;
    state_t      end_state;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign shamt   = ir_q[10:6];
    assign funct   = ir_q[5:0];
    assign imm_s   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_z   = {16'h0000, ir_q[15:0]};
    assign br_off  = {imm_s[29:0], 2'b00};
    assign jmp_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};

    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_bne  = (op == 6'h05);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign is_jr   = (op == 6'h00) && (funct == 6'h08);
    assign is_jalr = (op == 6'h00) && (funct == 6'h09);
    assign is_eret = (op == 6'h10) && (funct == 6'h18);

    assign br_taken = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));
    // R-type writes rd, everything else that reaches WB writes rt
    assign wb_dst   = (op == 6'h00) ? rd : rt;
    // IE is sampled before any update made in the same cycle (eret case)
    assign int_take = INT && ie_q && IRQ_EN;
    assign end_state = int_take ? S_INTR : S_FETCH;

    assign PC_out    = pc_q;
    assign Addr_out  = aluout_q;
    assign Data_out  = b_q;
    assign CPU_MIO   = (state_q == S_MEM);
    assign mem_w     = (state_q == S_MEM) && is_sw;
    assign state_out = state_q;

    // ALU for R-type and I-arith; alu_vld flags an instruction that goes to WB
    always_comb begin
        alu_vld = 1'b1;
        alu_res = 32'h0;
        if (op == 6'h00) begin
            case (funct)
                6'h20, 6'h21: alu_res = a_q + b_q;
                6'h22, 6'h23: alu_res = a_q - b_q;
                6'h24:        alu_res = a_q & b_q;
                6'h25:        alu_res = a_q | b_q;
                6'h26:        alu_res = a_q ^ b_q;
                6'h27:        alu_res = ~(a_q | b_q);
                6'h2A:        alu_res = {31'h0, $signed(a_q) < $signed(b_q)};
                6'h2B:        alu_res = {31'h0, a_q < b_q};
                6'h00:        alu_res = b_q << shamt;
                6'h02:        alu_res = b_q >> shamt;
                6'h03:        alu_res = $signed(b_q) >>> shamt;
                default:      alu_vld = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: alu_res = a_q + imm_s;
                6'h0A:        alu_res = {31'h0, $signed(a_q) < $signed(imm_s)};
                6'h0C:        alu_res = a_q & imm_z;
                6'h0D:        alu_res = a_q | imm_z;
                6'h0E:        alu_res = a_q ^ imm_z;
                6'h0F:        alu_res = {ir_q[15:0], 16'h0000};
                default:      alu_vld = 1'b0;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // FSM next-state: MEM holds until the bus accepts; every instruction end checks INT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (alu_vld)              state_d = S_WB;
                else if (is_lw || is_sw)  state_d = S_MEM;
                else                      state_d = end_state;
            end
            S_MEM:    if (MIO_ready) state_d = is_lw ? S_WB : end_state;
            S_WB:     state_d = end_state;
            S_INTR:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Datapath registers and register file, updated per FSM state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            aluout_q <= 32'h0;
            mdr_q    <= 32'h0;
            epc_q    <= 32'h0;
            ie_q     <= IRQ_EN;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q <= inst_in;
                    pc_q <= pc_q + 32'd4;
                end
                S_DECODE: begin
                    a_q <= rf_q[rs];
                    b_q <= rf_q[rt];
                end
                S_EXEC: begin
                    if (alu_vld)             aluout_q <= alu_res;
                    else if (is_lw || is_sw) aluout_q <= a_q + imm_s;
                    else if (br_taken)       pc_q <= pc_q + br_off;
                    else if (is_j)           pc_q <= jmp_tgt;
                    else if (is_jal) begin
                        pc_q      <= jmp_tgt;
                        rf_q[31]  <= pc_q;
                    end else if (is_jr)      pc_q <= a_q;
                    else if (is_jalr) begin
                        pc_q <= a_q;
                        if (rd != 5'd0) rf_q[rd] <= pc_q;
                    end else if (is_eret) begin
                        pc_q <= epc_q;
                        ie_q <= IRQ_EN;
                    end
                end
                S_MEM: begin
                    if (MIO_ready && is_lw) mdr_q <= Data_in;
                end
                S_WB: begin
                    if (wb_dst != 5'd0) rf_q[wb_dst] <= is_lw ? mdr_q : aluout_q;
                end
                S_INTR: begin
                    epc_q <= pc_q;
                    pc_q  <= INT_VECTOR;
                    ie_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
